wb_sram_arb: RTL and testbench

Two-port Wishbone arbiter that shares the single `wb_sram` async-SRAM slave between two bus masters (e.g. CPU instruction and data ports, or CPU and DMA). It grants the slave to one master at a time, holds the grant for a whole `cyc` tenure, and forwards the owner's signals to the slave combinationally. A watchdog terminates stalled transfers with `err`.

---
 rtl/wb_sram_pkg.sv | 25 ++
 rtl/wb_sram_arb_pick.sv | 29 ++
 rtl/wb_sram_arb.sv | 172 +++++++++++++++++
 tb/tb_wb_sram_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// Shared definitions for the wb_sram slave and its two-master Wishbone arbiter:
// arbiter FSM encodings, default bus widths and the watchdog counter width.
package wb_sram_pkg;

    localparam int WB_AW    = 17;
    localparam int WB_DW    = 32;
    localparam int WB_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    // One-hot owner for the grant output; ABORT and IDLE have no owner on the bus.
    function automatic logic [1:0] owner_onehot(input arb_state_e st);
        case (st)
            ST_OWN0: return 2'b01;
            ST_OWN1: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_sram_arb_pick.sv
// Combinational two-request picker with one-hot grant.
// Define WB_SRAM_ARB_RR_EN for round-robin on conflicts; otherwise req[0] always wins.
module wb_sram_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef WB_SRAM_ARB_RR_EN
    always_comb begin
        gnt = req;
        // On a conflict the requester that did not win last time goes first.
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = last;

    always_comb begin
        gnt = req;
        if (req[0]) begin
            gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/wb_sram_arb.sv
// Two-master Wishbone arbiter in front of wb_sram, with a stall watchdog that ends
// hung transfers with err. Build option: WB_SRAM_ARB_RR_EN selects round-robin picking.
module wb_sram_arb
    import wb_sram_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 63
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    localparam logic [WB_CNT_W-1:0] TO_VAL  = WB_CNT_W'(TIMEOUT);
    localparam logic [WB_CNT_W-1:0] CNT_MAX = '1;
    localparam bit                  WD_EN   = (TIMEOUT != 0);

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic                r_last;
    logic                w_last_next;
    logic [WB_CNT_W-1:0] r_cnt;
    logic                r_abort_m1;
    logic [1:0]          w_req;
    logic [1:0]          w_pick;
    logic                w_own;
    logic                w_own_stb;
    logic                w_expire;

    assign w_req = {m1_cyc_i, m0_cyc_i};

    wb_sram_arb_pick u_pick (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_pick)
    );

    assign w_own     = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    assign w_own_stb = (r_state == ST_OWN1) ? m1_stb_i : m0_stb_i;
    // An ack in the same cycle as the limit is honoured instead of aborting.
    assign w_expire  = WD_EN && (r_cnt == TO_VAL) && !s_ack_i;

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[0]) begin
                    w_state_next = ST_OWN0;
                end else if (w_pick[1]) begin
                    w_state_next = ST_OWN1;
                end
                if (&w_req) begin
                    w_last_next = w_pick[1];
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_expire) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_expire) begin
                    w_state_next = ST_ABORT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_abort_m1 <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            if (!w_own || s_ack_i) begin
                r_cnt <= '0;
            end else if (w_own_stb && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + WB_CNT_W'(1);
            end
            // Remember whose transfer was killed so err goes back to that master.
            if (w_own && (w_state_next == ST_ABORT)) begin
                r_abort_m1 <= (r_state == ST_OWN1);
            end
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = owner_onehot(r_state);
        case (r_state)
            ST_OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
            end
            ST_OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
            end
            ST_ABORT: begin
                m0_err_o = !r_abort_m1;
                m1_err_o = r_abort_m1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_sram_arb.sv
// Self-checking bench for wb_sram_arb: directed scenarios followed by random traffic,
// every cycle compared against an ownership-level reference model.
module tb_wb_sram_arb;

    localparam int AW      = 17;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;
`ifdef WB_SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tb_cyc [2];
    logic          tb_stb [2];
    logic          tb_we  [2];
    logic [3:0]    tb_sel [2];
    logic [AW-1:0] tb_adr [2];
    logic [DW-1:0] tb_dat [2];
    logic [DW-1:0] tb_sdat;
    logic          tb_sack;

    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [1:0]    gnt_o;

    // Reference model: who owns the bus, who is being aborted, stall run length.
    int own;
    int abort_who;
    int stall;
    int last;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_sram_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc_i (tb_cyc[0]),
        .m0_stb_i (tb_stb[0]),
        .m0_we_i  (tb_we[0]),
        .m0_sel_i (tb_sel[0]),
        .m0_adr_i (tb_adr[0]),
        .m0_dat_i (tb_dat[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (tb_cyc[1]),
        .m1_stb_i (tb_stb[1]),
        .m1_we_i  (tb_we[1]),
        .m1_sel_i (tb_sel[1]),
        .m1_adr_i (tb_adr[1]),
        .m1_dat_i (tb_dat[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (tb_sdat),
        .s_ack_i  (tb_sack),
        .gnt_o    (gnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            tb_cyc[m] = 1'b0;
            tb_stb[m] = 1'b0;
            tb_we[m]  = 1'b0;
            tb_sel[m] = '0;
            tb_adr[m] = '0;
            tb_dat[m] = '0;
        end
        tb_sack = 1'b0;
        tb_sdat = '0;
    endtask

    task automatic model_reset();
        own       = -1;
        abort_who = -1;
        stall     = 0;
        last      = 1;
    endtask

    task automatic grant(input int w);
        own   = w;
        stall = 0;
        $display("[TB] t=%0t grant m%0d", $time, w);
    endtask

    // Advance the model by one rising edge using the inputs held during the cycle.
    task automatic model_edge();
        if (abort_who >= 0) begin
            abort_who = -1;
            own       = -1;
        end else if (own < 0) begin
            if (tb_cyc[0] && tb_cyc[1]) begin
                last = RR ? (1 - last) : 0;
                grant(last);
            end else if (tb_cyc[0]) begin
                grant(0);
            end else if (tb_cyc[1]) begin
                grant(1);
            end
        end else begin
            if (!tb_cyc[own]) begin
                own = -1;
            end else if (stall == TIMEOUT && !tb_sack) begin
                $display("[TB] t=%0t watchdog abort m%0d", $time, own);
                abort_who = own;
                own       = -1;
            end else if (tb_sack) begin
                stall = 0;
            end else if (tb_stb[own] && stall < 255) begin
                stall++;
            end
        end
    endtask

    // Mid-cycle: compare every DUT output with what the model expects.
    task automatic half();
        logic [1:0]    e_gnt, e_ack, e_err;
        logic          e_cyc, e_stb, e_we;
        logic [3:0]    e_sel;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        #4;
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_sel = '0; e_adr = '0; e_dat = '0;
        if (abort_who >= 0) begin
            e_err[abort_who] = 1'b1;
        end else if (own >= 0) begin
            e_cyc        = tb_cyc[own];
            e_stb        = tb_stb[own];
            e_we         = tb_we[own];
            e_sel        = tb_sel[own];
            e_adr        = tb_adr[own];
            e_dat        = tb_dat[own];
            e_ack[own]   = tb_sack;
            e_gnt[own]   = 1'b1;
        end
        chk("gnt",    64'(gnt_o),    64'(e_gnt));
        chk("s_cyc",  64'(s_cyc_o),  64'(e_cyc));
        chk("s_stb",  64'(s_stb_o),  64'(e_stb));
        chk("s_we",   64'(s_we_o),   64'(e_we));
        chk("s_sel",  64'(s_sel_o),  64'(e_sel));
        chk("s_adr",  64'(s_adr_o),  64'(e_adr));
        chk("s_dat",  64'(s_dat_o),  64'(e_dat));
        chk("m0_ack", 64'(m0_ack_o), 64'(e_ack[0]));
        chk("m1_ack", 64'(m1_ack_o), 64'(e_ack[1]));
        chk("m0_err", 64'(m0_err_o), 64'(e_err[0]));
        chk("m1_err", 64'(m1_err_o), 64'(e_err[1]));
        chk("m0_dat", 64'(m0_dat_o), 64'(tb_sdat));
        chk("m1_dat", 64'(m1_dat_o), 64'(tb_sdat));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic req(input int m, input logic we, input logic [3:0] sel,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        tb_cyc[m] = 1'b1;
        tb_stb[m] = 1'b1;
        tb_we[m]  = we;
        tb_sel[m] = sel;
        tb_adr[m] = adr;
        tb_dat[m] = dat;
    endtask

    task automatic drop(input int m);
        tb_cyc[m] = 1'b0;
        tb_stb[m] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clr();
        model_reset();
        #2;
        chk("rst_scyc", 64'(s_cyc_o), 64'd0);
        chk("rst_gnt",  64'(gnt_o),   64'd0);
        chk("rst_sadr", 64'(s_adr_o), 64'd0);
        chk("rst_ssel", 64'(s_sel_o), 64'd0);
        chk("rst_ack",  64'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), 64'd0);
        #19;
        rst = 1'b1;
        tick();

        // Single read by m0
        req(0, 1'b0, 4'hF, 17'h05500, '0);
        half(); tick();
        half();
        chk("rd_gnt", 64'(gnt_o),   64'h1);
        chk("rd_adr", 64'(s_adr_o), 64'h05500);
        tick();
        tb_sack = 1'b1; tb_sdat = 32'hADADADAD;
        half();
        chk("rd_ack",  64'(m0_ack_o), 64'h1);
        chk("rd_data", 64'(m0_dat_o), 64'hADADADAD);
        tick();
        tb_sack = 1'b0; drop(0);
        half(); tick();
        half();
        chk("rd_idle", 64'(gnt_o), 64'h0);
        tick();
        $display("[TB] single read done");

        // Conflict, then a second conflict
        req(0, 1'b0, 4'hF, 17'h00010, '0);
        req(1, 1'b0, 4'hF, 17'h00020, '0);
        half(); tick();
        half();
        chk("cf1_gnt", 64'(gnt_o), 64'h1);
        tb_sack = 1'b1;
        tick();
        half(); tick();
        tb_sack = 1'b0; drop(0);
        half(); tick();
        half();
        chk("cf1_dead", 64'(gnt_o), 64'h0);
        tick();
        half();
        chk("cf1_m1", 64'(gnt_o), 64'h2);
        tb_sack = 1'b1;
        tick();
        tb_sack = 1'b0; drop(1);
        half(); tick();
        req(0, 1'b0, 4'hF, 17'h00030, '0);
        req(1, 1'b0, 4'hF, 17'h00040, '0);
        half(); tick();
        half();
        chk("cf2_gnt", 64'(gnt_o), RR ? 64'h2 : 64'h1);
        tick();
        drop(0); drop(1);
        half(); tick();
        half(); tick();
        $display("[TB] conflict sequence done");

        // Write forwarding from m1
        req(1, 1'b1, 4'b1101, 17'h0AA00, 32'hDEADBEEF);
        half(); tick();
        tb_sack = 1'b1;
        half();
        chk("wr_sel", 64'(s_sel_o),  64'hD);
        chk("wr_dat", 64'(s_dat_o),  64'hDEADBEEF);
        chk("wr_adr", 64'(s_adr_o),  64'h0AA00);
        chk("wr_we",  64'(s_we_o),   64'h1);
        chk("wr_m1a", 64'(m1_ack_o), 64'h1);
        chk("wr_m0a", 64'(m0_ack_o), 64'h0);
        tick();
        tb_sack = 1'b0; drop(1);
        half(); tick();
        $display("[TB] write forwarding done");

        // Watchdog abort with m1 waiting
        req(0, 1'b0, 4'hF, 17'h01230, '0);
        half(); tick();
        req(1, 1'b0, 4'hF, 17'h04560, '0);
        for (int i = 0; i <= TIMEOUT; i++) begin
            half();
            chk("wd_noerr", 64'(m0_err_o), 64'h0);
            tick();
        end
        half();
        chk("wd_err",  64'(m0_err_o), 64'h1);
        chk("wd_scyc", 64'(s_cyc_o),  64'h0);
        chk("wd_m1e",  64'(m1_err_o), 64'h0);
        drop(0);
        tick();
        half();
        chk("wd_once", 64'(m0_err_o), 64'h0);
        tick();
        half();
        chk("wd_m1gnt", 64'(gnt_o), 64'h2);
        tb_sack = 1'b1;
        tick();
        tb_sack = 1'b0; drop(1);
        half(); tick();
        $display("[TB] watchdog abort done");

        // Ack in the same cycle the counter reaches the limit
        req(0, 1'b0, 4'hF, 17'h00100, '0);
        half(); tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            half(); tick();
        end
        tb_sack = 1'b1; tb_sdat = 32'h12345678;
        half();
        chk("ae_ack", 64'(m0_ack_o), 64'h1);
        chk("ae_err", 64'(m0_err_o), 64'h0);
        tick();
        tb_sack = 1'b0;
        half();
        chk("ae_noerr", 64'(m0_err_o), 64'h0);
        chk("ae_gnt",   64'(gnt_o),    64'h1);
        tick();
        drop(0);
        half(); tick();
        $display("[TB] ack at expiry done");

        // Reset during an m1 stall
        req(1, 1'b0, 4'hF, 17'h00200, '0);
        half(); tick();
        half(); tick();
        #2;
        rst = 1'b0;
        #1;
        chk("rr_scyc", 64'(s_cyc_o), 64'h0);
        chk("rr_gnt",  64'(gnt_o),   64'h0);
        clr();
        model_reset();
        #1;
        rst = 1'b1;
        tick();
        req(0, 1'b0, 4'hF, 17'h00300, '0);
        req(1, 1'b0, 4'hF, 17'h00400, '0);
        half(); tick();
        half();
        chk("rr_first", 64'(gnt_o), 64'h1);
        tick();
        drop(0); drop(1);
        half(); tick();
        half(); tick();
        $display("[TB] reset mid-transfer done");

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!tb_cyc[m]) begin
                    tb_cyc[m] = ($urandom_range(0, 99) < 30);
                end else if ($urandom_range(0, 99) < 12) begin
                    tb_cyc[m] = 1'b0;
                end
                tb_stb[m] = tb_cyc[m] && ($urandom_range(0, 99) < 75);
                tb_we[m]  = 1'($urandom);
                tb_sel[m] = 4'($urandom);
                tb_adr[m] = AW'($urandom);
                tb_dat[m] = $urandom;
            end
            tb_sdat = $urandom;
            tb_sack = (own >= 0) && (abort_who < 0) && ($urandom_range(0, 99) < 30);
            half();
            tick();
        end
        $display("[TB] random traffic done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
